// File: rtl/gold_code_generator.sv
// Gold-code chip generator: two 10-stage maximal-length LFSRs (G1, G2) XORed
// into a chip stream, with a chip counter and a multiplexed 8-bit output view.
module gold_code_generator (
    input  logic       clk,
    input  logic       rst,
    input  logic       mux_sel,
    input  logic       load_gold_n,
    input  logic [3:0] seed_in,
    output logic [7:0] io_out
);

    logic [9:0] g1_q, g1_d;
    logic [9:0] g2_q, g2_d;
    logic [9:0] count_q, count_d;

    logic g1_fb, g2_fb;
    logic g1_out, g2_out, gold, epoch;

    // Feedback taps: G1 = x^10+x^3+1, G2 = x^10+x^9+x^8+x^6+x^3+x^2+1
    always_comb begin
        g1_fb = g1_q[2] ^ g1_q[9];
        g2_fb = g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9];
    end

    // Next state: load/restart has priority over the free-running shift
    always_comb begin
        g1_d    = g1_q;
        g2_d    = g2_q;
        count_d = count_q;
        if (!load_gold_n) begin
            g1_d    = '1;
            // Upper six stages forced to ones so G2 can never lock up at zero
            g2_d    = {6'b111111, ~seed_in};
            count_d = '0;
        end else begin
            g1_d    = {g1_q[8:0], g1_fb};
            g2_d    = {g2_q[8:0], g2_fb};
            count_d = (count_q == 10'd1022) ? '0 : count_q + 10'd1;
        end
    end

    // State registers with asynchronous reset to the all-ones seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1_q    <= '1;
            g2_q    <= '1;
            count_q <= '0;
        end else begin
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            count_q <= count_d;
        end
    end

    // Chip outputs taken straight from the current state (no pipeline)
    always_comb begin
        g1_out = g1_q[9];
        g2_out = g2_q[9];
        gold   = g1_out ^ g2_out;
        epoch  = (count_q == 10'd0);
    end

    // Output view select is purely combinational so mux_sel may run faster than clk
    always_comb begin
        if (mux_sel)
            io_out = {gold, g1_out, g2_out, epoch, 2'b00, count_q[9:8]};
        else
            io_out = count_q[7:0];
    end

endmodule

// File: tb/tb_gold_code_generator.sv
// Bench for gold_code_generator: chip sequences are precomputed as output-bit
// recurrences (o[t] from earlier chips), and the DUT is checked every cycle in
// both output views against that table indexed by chip number and seed.
module tb_gold_code_generator;

    logic       clk;
    logic       rst;
    logic       mux_sel;
    logic       load_gold_n;
    logic [3:0] seed_in;
    logic [7:0] io_out;

    int n_cmp;
    int n_err;

    bit g1tab [1023];
    bit g2tab [16][1023];

    int k;   // chip index since last reset/load
    int sd;  // seed value in effect (reset behaves like seed 0)

    gold_code_generator dut (
        .clk         (clk),
        .rst         (rst),
        .mux_sel     (mux_sel),
        .load_gold_n (load_gold_n),
        .seed_in     (seed_in),
        .io_out      (io_out)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Output sequence of an LFSR expressed as a recurrence on its own chips.
    task automatic build_tables();
        bit o [1023];
        logic [9:0] init;
        for (int unsigned t = 0; t < 1023; t++) begin
            if (t < 10) o[t] = 1'b1;
            else        o[t] = o[t-3] ^ o[t-10];
            g1tab[t] = o[t];
        end
        for (int unsigned s = 0; s < 16; s++) begin
            init = {6'b111111, ~4'(s)};
            for (int unsigned t = 0; t < 1023; t++) begin
                if (t < 10) o[t] = init[9-t];
                else        o[t] = o[t-2] ^ o[t-3] ^ o[t-6] ^ o[t-8] ^ o[t-9] ^ o[t-10];
                g2tab[s][t] = o[t];
            end
        end
    endtask

    function automatic logic [7:0] exp_view(input logic v);
        logic [9:0] c;
        logic a, b;
        c = 10'(k);
        a = g1tab[k];
        b = g2tab[sd][k];
        return v ? {a ^ b, a, b, (c == 10'd0), 2'b00, c[9:8]} : c[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t k=%0d seed=%0d)",
                     name, act, exp, $time, k, sd);
        end
    endtask

    task automatic peek(input logic v, output logic [7:0] val);
        mux_sel = v;
        #1;
        val = io_out;
    endtask

    // Per-cycle compare of both views against the model
    task automatic check_both(input string tag);
        logic [7:0] v;
        peek(1'b0, v);
        check({tag, "_view0"}, v, exp_view(1'b0));
        peek(1'b1, v);
        check({tag, "_view1"}, v, exp_view(1'b1));
        mux_sel = 1'($urandom_range(0, 1));
    endtask

    // Drive inputs, advance one edge, update the model, compare after the edge.
    task automatic step(input logic ld, input logic [3:0] s_in, input string tag);
        load_gold_n = ld;
        seed_in     = s_in;
        @(posedge clk);
        if (!ld) begin
            k  = 0;
            sd = int'(s_in);
        end else begin
            k = (k + 1) % 1023;
        end
        @(negedge clk);
        check_both(tag);
    endtask

    initial begin
        logic [7:0] v;
        int epochs;

        n_cmp = 0;
        n_err = 0;
        build_tables();

        // Reset applied without any clock edge
        rst = 1'b1; load_gold_n = 1'b1; seed_in = 4'd0; mux_sel = 1'b1;
        k = 0; sd = 0;
        #1;
        check("reset_view1", io_out, 8'h70);
        peek(1'b0, v);
        check("reset_view0", v, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        check_both("post_reset");

        // Free run from reset over more than one full period
        epochs = 0;
        for (int j = 1; j <= 1100; j++) begin
            step(1'b1, 4'($urandom_range(0, 15)), "run");
            peek(1'b1, v);
            if (v[4]) epochs++;
            if (j < 10) begin
                check("early_chip_view1", v, 8'h60);
                peek(1'b0, v);
                check("early_count", v, 8'(j));
            end
            if (j == 10) check("chip10_view1", v, 8'h00);
            if (j == 1022) begin
                peek(1'b0, v);
                check("count_1022_lo", v, 8'hFE);
                peek(1'b1, v);
                check("count_1022_hi", {6'b0, v[1:0]}, 8'h03);
            end
            if (j == 1023) check("wrap_view1", v, 8'h70);
        end
        check("epoch_pulses", 8'(epochs), 8'd1);

        // Load held low for two edges with seed 0101
        step(1'b0, 4'b0101, "load_a");
        step(1'b0, 4'b0101, "load_b");
        peek(1'b1, v);
        check("load_view1", v, 8'h70);
        for (int j = 1; j <= 12; j++) begin
            step(1'b1, 4'($urandom_range(0, 15)), "seed5");
            peek(1'b1, v);
            if (j == 7) check("seed5_chip7", v, 8'hC0);
            if (j == 8) check("seed5_chip8", v, 8'h60);
            if (j == 9) check("seed5_chip9", v, 8'hC0);
        end

        // Fast view toggling between edges must not disturb state
        for (int j = 0; j < 20; j++) begin
            peek(1'(j % 2), v);
            check("toggle", v, exp_view(1'(j % 2)));
        end
        step(1'b1, 4'd0, "after_toggle");

        // Randomised run with occasional reloads
        for (int j = 0; j < 3000; j++) begin
            step(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)), "rand");
        end

        // Mid-sequence asynchronous reset at count 500
        step(1'b0, 4'($urandom_range(0, 15)), "pre500_load");
        for (int j = 0; j < 500; j++) step(1'b1, 4'($urandom_range(0, 15)), "to500");
        peek(1'b0, v);
        check("count500_lo", v, 8'hF4);
        #25;
        rst = 1'b1;
        load_gold_n = 1'b0;
        k = 0; sd = 0;
        peek(1'b0, v);
        check("midreset_view0", v, 8'h00);
        peek(1'b1, v);
        check("midreset_view1", v, 8'h70);
        @(posedge clk);
        @(negedge clk);
        check_both("reset_held");
        // Release reset and load in the same interval
        rst = 1'b0;
        for (int j = 0; j < 20; j++) step(1'b1, 4'($urandom_range(0, 15)), "post_midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
